multicycle_sequencer: RTL and testbench

- Multi-cycle control FSM for the 24-bit CPU; sequences fetch, decode, execute, memory and write-back phases around the shared ALU, register file and single memory port.
- Decodes the same opcode set as the combinational control unit: R-format 0110, MUL = R-format with Funct 0101, LS 0010, SS 0011, BEQ 0100, ADDI 0001.
- Adds a memory-ready handshake, a multi-cycle MUL wait, a halt on illegal opcodes, and a retired-instruction counter.

---
 rtl/multicycle_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// ============================================================================
// multicycle_sequencer : multi-cycle control FSM for the 24-bit CPU
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int RETIRE_W   = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [3:0]          i_opcode,
  input  logic [3:0]          i_funct,
  input  logic                i_zero,
  input  logic                i_mem_ready,
  output logic                o_instr_req,
  output logic                o_data_req,
  output logic                o_data_we,
  output logic                o_ir_write,
  output logic                o_pc_write,
  output logic                o_pc_src,
  output logic                o_alu_src,
  output logic [1:0]          o_alu_op,
  output logic                o_reg_dst,
  output logic                o_mem_to_reg,
  output logic                o_reg_write,
  output logic                o_mul_reg_write,
  output logic                o_halted,
  output logic [2:0]          o_state,
  output logic [RETIRE_W-1:0] o_retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_MULW   = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [2:0] C_R    = 3'd0;
  localparam logic [2:0] C_MUL  = 3'd1;
  localparam logic [2:0] C_LS   = 3'd2;
  localparam logic [2:0] C_SS   = 3'd3;
  localparam logic [2:0] C_BEQ  = 3'd4;
  localparam logic [2:0] C_ADDI = 3'd5;
  localparam logic [2:0] C_ILL  = 3'd6;

  localparam logic [3:0] c_mul_load = 4'(MUL_CYCLES - 1);

  logic [2:0]          r_state;
  logic [2:0]          r_cls;
  logic [3:0]          r_mul_cnt;
  logic [RETIRE_W-1:0] r_retired;
  logic [2:0]          w_next;
  logic [2:0]          w_dec_cls;
  logic                w_retire;
  logic                w_cls_alu_src;
  logic [1:0]          w_cls_alu_op;

  always_comb begin
    w_dec_cls = C_ILL;
    case (i_opcode)
      4'b0110: w_dec_cls = (i_funct == 4'b0101) ? C_MUL : C_R;
      4'b0010: w_dec_cls = C_LS;
      4'b0011: w_dec_cls = C_SS;
      4'b0100: w_dec_cls = C_BEQ;
      4'b0001: w_dec_cls = C_ADDI;
      default: w_dec_cls = C_ILL;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:  if (i_mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (w_dec_cls)
          C_MUL:   w_next = S_MULW;
          C_ILL:   w_next = S_HALT;
          default: w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (r_cls)
          C_BEQ: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
          C_LS, C_SS: w_next = S_MEM;
          default:    w_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (i_mem_ready) begin
          w_next   = (r_cls == C_SS) ? S_FETCH : S_WB;
          w_retire = (r_cls == C_SS);
        end
      end
      S_WB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_MULW: begin
        if (r_mul_cnt == 4'd0) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_FETCH;
      r_cls     <= C_R;
      r_mul_cnt <= 4'd0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_cls <= w_dec_cls;
        if (w_dec_cls == C_MUL) r_mul_cnt <= c_mul_load;
      end else if (r_state == S_MULW && r_mul_cnt != 4'd0) begin
        r_mul_cnt <= r_mul_cnt - 4'd1;
      end
      if (w_retire) r_retired <= r_retired + RETIRE_W'(1);
    end
  end

  assign w_cls_alu_src = (r_cls == C_ADDI) || (r_cls == C_LS) || (r_cls == C_SS);
  assign w_cls_alu_op  = (r_cls == C_BEQ) ? 2'b01 : (r_cls == C_R) ? 2'b10 : 2'b00;

  // Every control output is held low while reset is asserted.
  always_comb begin
    o_instr_req     = 1'b0;
    o_data_req      = 1'b0;
    o_data_we       = 1'b0;
    o_ir_write      = 1'b0;
    o_pc_write      = 1'b0;
    o_pc_src        = 1'b0;
    o_alu_src       = 1'b0;
    o_alu_op        = 2'b00;
    o_reg_dst       = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_reg_write     = 1'b0;
    o_mul_reg_write = 1'b0;
    o_halted        = 1'b0;
    if (!i_rst) begin
      case (r_state)
        S_FETCH: begin
          o_instr_req = 1'b1;
          o_ir_write  = i_mem_ready;
          o_pc_write  = i_mem_ready;
        end
        S_EXEC: begin
          o_alu_src = w_cls_alu_src;
          o_alu_op  = w_cls_alu_op;
          o_reg_dst = (r_cls == C_R);
          if (r_cls == C_BEQ) begin
            o_pc_write = i_zero;
            o_pc_src   = 1'b1;
          end
        end
        S_MEM: begin
          o_data_req = 1'b1;
          o_data_we  = (r_cls == C_SS);
          o_alu_src  = 1'b1;
        end
        S_WB: begin
          o_reg_write  = 1'b1;
          o_mem_to_reg = (r_cls == C_LS);
          o_reg_dst    = (r_cls == C_R);
          o_alu_src    = w_cls_alu_src;
          o_alu_op     = w_cls_alu_op;
        end
        S_MULW: begin
          o_alu_op        = 2'b11;
          o_mul_reg_write = (r_mul_cnt == 4'd0);
        end
        S_HALT:  o_halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign o_state   = r_state;
  assign o_retired = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
// ============================================================================
// tb_multicycle_sequencer : phase-list reference model, directed + random run
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_sequencer;

  localparam int MULC = 4;

  logic clk = 1'b0, rst = 1'b1, mr = 1'b0, zero = 1'b0;
  logic [3:0] op = 4'd0, fn = 4'd0;

  logic a_ir, a_dr, a_dw, a_irw, a_pcw, a_pcs, a_as, a_rd, a_mtr, a_rw, a_mrw, a_h;
  logic [1:0] a_op;
  logic [2:0] a_st;
  logic [15:0] a_ret;
  logic b_ir, b_dr, b_dw, b_irw, b_pcw, b_pcs, b_as, b_rd, b_mtr, b_rw, b_mrw, b_h;
  logic [1:0] b_op;
  logic [2:0] b_st;
  logic [1:0] b_ret;
  logic [13:0] a_vec, b_vec;

  assign a_vec = {a_ir, a_dr, a_dw, a_irw, a_pcw, a_pcs, a_as, a_op, a_rd, a_mtr, a_rw, a_mrw, a_h};
  assign b_vec = {b_ir, b_dr, b_dw, b_irw, b_pcw, b_pcs, b_as, b_op, b_rd, b_mtr, b_rw, b_mrw, b_h};

  multicycle_sequencer #(.MUL_CYCLES(MULC), .RETIRE_W(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_opcode(op), .i_funct(fn), .i_zero(zero), .i_mem_ready(mr),
    .o_instr_req(a_ir), .o_data_req(a_dr), .o_data_we(a_dw), .o_ir_write(a_irw),
    .o_pc_write(a_pcw), .o_pc_src(a_pcs), .o_alu_src(a_as), .o_alu_op(a_op),
    .o_reg_dst(a_rd), .o_mem_to_reg(a_mtr), .o_reg_write(a_rw), .o_mul_reg_write(a_mrw),
    .o_halted(a_h), .o_state(a_st), .o_retired(a_ret)
  );

  multicycle_sequencer #(.MUL_CYCLES(MULC), .RETIRE_W(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_opcode(op), .i_funct(fn), .i_zero(zero), .i_mem_ready(mr),
    .o_instr_req(b_ir), .o_data_req(b_dr), .o_data_we(b_dw), .o_ir_write(b_irw),
    .o_pc_write(b_pcw), .o_pc_src(b_pcs), .o_alu_src(b_as), .o_alu_op(b_op),
    .o_reg_dst(b_rd), .o_mem_to_reg(b_mtr), .o_reg_write(b_rw), .o_mul_reg_write(b_mrw),
    .o_halted(b_h), .o_state(b_st), .o_retired(b_ret)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Phases: 0 fetch, 1 decode, 2 exec, 3 mem, 4 write-back, 5 mul wait, 6 halt.
  // Classes: 0 R, 1 MUL, 2 LS, 3 SS, 4 BEQ, 5 ADDI, 6 illegal.
  int m_cur = 0, m_cls = 0, m_ret = 0;
  bit m_valid = 1'b0;
  int q[$];

  function automatic int decode(input logic [3:0] o, input logic [3:0] f);
    case (o)
      4'h6:    return (f == 4'h5) ? 1 : 0;
      4'h2:    return 2;
      4'h3:    return 3;
      4'h4:    return 4;
      4'h1:    return 5;
      default: return 6;
    endcase
  endfunction

  function automatic logic [13:0] expv(input int cur, input int cls, input logic m,
                                       input logic z, input bit last);
    logic ir = 0, dr = 0, dw = 0, irw = 0, pcw = 0, pcs = 0, as = 0, rd = 0;
    logic mtr = 0, rw = 0, mrw = 0, h = 0;
    logic [1:0] ao = 2'b00;
    logic [1:0] cls_op;
    cls_op = (cls == 4) ? 2'b01 : (cls == 0) ? 2'b10 : 2'b00;
    case (cur)
      0: begin ir = 1; irw = m; pcw = m; end
      2: begin
        as = (cls == 2 || cls == 3 || cls == 5); ao = cls_op; rd = (cls == 0);
        if (cls == 4) begin pcw = z; pcs = 1; end
      end
      3: begin dr = 1; dw = (cls == 3); as = 1; end
      4: begin
        rw = 1; mtr = (cls == 2); rd = (cls == 0);
        as = (cls == 2 || cls == 3 || cls == 5); ao = cls_op;
      end
      5: begin ao = 2'b11; mrw = last; end
      6: h = 1;
      default: ;
    endcase
    return {ir, dr, dw, irw, pcw, pcs, as, ao, rd, mtr, rw, mrw, h};
  endfunction

  // Single compare process: check outputs this cycle, then step the model.
  always @(negedge clk) begin
    #1;
    if (m_valid || rst) begin
      chk("ctrl", 32'(a_vec), rst ? 32'd0 : 32'(expv(m_cur, m_cls, mr, zero, q.size() == 0)));
      chk("ctrl_w2", 32'(b_vec), rst ? 32'd0 : 32'(expv(m_cur, m_cls, mr, zero, q.size() == 0)));
    end
    if (m_valid) begin
      chk("state", 32'(a_st), 32'(m_cur));
      chk("retired", 32'(a_ret), m_ret & 32'hFFFF);
      chk("state_w2", 32'(b_st), 32'(m_cur));
      chk("retired_w2", 32'(b_ret), m_ret & 32'h3);
    end
    if (rst) begin
      m_cur = 0; m_ret = 0; m_cls = 0; q.delete(); m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_cur)
        0: if (mr) m_cur = 1;
        1: begin
          m_cls = decode(op, fn);
          case (m_cls)
            1: for (int i = 0; i < MULC; i++) q.push_back(5);
            2: begin q.push_back(2); q.push_back(3); q.push_back(4); end
            3: begin q.push_back(2); q.push_back(3); end
            4: q.push_back(2);
            6: q.push_back(6);
            default: begin q.push_back(2); q.push_back(4); end
          endcase
          m_cur = q.pop_front();
        end
        6: m_cur = 6;
        default: begin
          if (!(m_cur == 3 && !mr)) begin
            if (q.size() == 0) begin m_ret++; m_cur = 0; end
            else m_cur = q.pop_front();
          end
        end
      endcase
    end
  end

  task automatic cyc(input logic r, input logic m, input logic z,
                     input logic [3:0] o, input logic [3:0] f);
    @(negedge clk);
    rst = r; mr = m; zero = z; op = o; fn = f;
  endtask

  task automatic ds(input logic r, input logic m, input logic z,
                    input logic [3:0] o, input logic [3:0] f, input int es);
    cyc(r, m, z, o, f);
    #2;
    if (es >= 0) chk("dir_state", 32'(a_st), 32'(es));
  endtask

  int hcnt = 0;
  logic [3:0] legal [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h6};

  initial begin
    // ADDI: 0,1,2,4,0
    ds(1, 1, 0, 4'h1, 4'h0, -1);
    ds(0, 1, 0, 4'h1, 4'h0, 0);
    ds(0, 1, 0, 4'h1, 4'h0, 1);
    ds(0, 1, 0, 4'h1, 4'h0, 2);
    ds(0, 1, 0, 4'h1, 4'h0, 4);
    chk("addi_regwrite", 32'(a_rw), 1); chk("addi_alusrc", 32'(a_as), 1);
    chk("addi_regdst", 32'(a_rd), 0);
    ds(0, 1, 1, 4'h4, 4'h0, 0);
    chk("addi_retired", 32'(a_ret), 1);
    // BEQ taken then not taken
    ds(0, 1, 1, 4'h4, 4'h0, 1);
    ds(0, 1, 1, 4'h4, 4'h0, 2);
    chk("beq_t_pcwrite", 32'(a_pcw), 1); chk("beq_t_pcsrc", 32'(a_pcs), 1);
    ds(0, 1, 0, 4'h4, 4'h0, 0);
    ds(0, 1, 0, 4'h4, 4'h0, 1);
    ds(0, 1, 0, 4'h4, 4'h0, 2);
    chk("beq_nt_pcwrite", 32'(a_pcw), 0);
    ds(0, 1, 0, 4'h6, 4'h5, 0);
    chk("beq_retired", 32'(a_ret), 3);
    // MUL: four MUL_WAIT cycles, write only in the last
    ds(0, 1, 0, 4'h6, 4'h5, 1);
    for (int i = 0; i < 4; i++) begin
      ds(0, 1, 0, 4'h6, 4'h5, 5);
      chk("mul_mulrw", 32'(a_mrw), (i == 3) ? 1 : 0);
      chk("mul_regwrite", 32'(a_rw), 0);
    end
    ds(0, 1, 0, 4'hF, 4'h0, 0);
    chk("mul_retired", 32'(a_ret), 4);
    // Illegal opcode halts until reset
    ds(0, 1, 0, 4'hF, 4'h0, 1);
    for (int i = 0; i < 20; i++) begin
      ds(0, logic'(i % 2), 0, 4'hF, 4'h0, 6);
      chk("halt_halted", 32'(a_h), 1);
    end
    ds(1, 1, 0, 4'h2, 4'h0, -1);
    ds(0, 1, 0, 4'h2, 4'h0, 0);
    chk("halt_reset_retired", 32'(a_ret), 0);
    // LS with three stalled MEM cycles
    ds(0, 1, 0, 4'h2, 4'h0, 1);
    ds(0, 1, 0, 4'h2, 4'h0, 2);
    for (int i = 0; i < 3; i++) ds(0, 0, 0, 4'h2, 4'h0, 3);
    ds(0, 1, 0, 4'h2, 4'h0, 3);
    chk("ls_datareq", 32'(a_dr), 1); chk("ls_datawe", 32'(a_dw), 0);
    ds(0, 1, 0, 4'h2, 4'h0, 4);
    chk("ls_memtoreg", 32'(a_mtr), 1); chk("ls_regwrite", 32'(a_rw), 1);
    ds(0, 1, 0, 4'h6, 4'h5, 0);
    chk("ls_retired", 32'(a_ret), 1);
    // Reset during second MUL_WAIT cycle
    ds(0, 1, 0, 4'h6, 4'h5, 1);
    ds(0, 1, 0, 4'h6, 4'h5, 5);
    ds(1, 1, 0, 4'h6, 4'h5, 5);
    chk("rstmul_mulrw", 32'(a_mrw), 0); chk("rstmul_regwrite", 32'(a_rw), 0);
    ds(0, 1, 0, 4'h3, 4'h0, 0);
    chk("rstmul_retired", 32'(a_ret), 0);
    // Reset during stalled SS MEM
    ds(0, 1, 0, 4'h3, 4'h0, 1);
    ds(0, 1, 0, 4'h3, 4'h0, 2);
    ds(0, 0, 0, 4'h3, 4'h0, 3);
    ds(1, 0, 0, 4'h3, 4'h0, 3);
    chk("rstss_datawe", 32'(a_dw), 0); chk("rstss_datareq", 32'(a_dr), 0);
    ds(0, 1, 0, 4'h3, 4'h0, 0);
    chk("rstss_retired", 32'(a_ret), 0);
    // Four SS: 2-bit counter wraps to 0
    for (int k = 0; k < 4; k++) begin
      ds(0, 1, 0, 4'h3, 4'h0, 1);
      ds(0, 1, 0, 4'h3, 4'h0, 2);
      ds(0, 1, 0, 4'h3, 4'h0, 3);
      ds(0, 1, 0, 4'h3, 4'h0, 0);
    end
    chk("ss4_retired", 32'(a_ret), 4);
    chk("ss4_retired_w2", 32'(b_ret), 0);

    // Randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      hcnt = (m_cur == 6) ? hcnt + 1 : 0;
      cyc(($urandom % 80 == 0) || (hcnt > 6),
          ($urandom % 4) != 0,
          logic'($urandom % 2),
          ($urandom % 30 == 0) ? 4'($urandom % 16) : legal[$urandom % 5],
          ($urandom % 2 == 0) ? 4'h5 : 4'($urandom % 16));
    end
    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
